hdlc_tx_framer: RTL and testbench

HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

---
 rtl/hdlc_tx_framer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer.
// Takes payload bytes through a one-entry holding buffer and serialises them
// LSB first between opening and closing flags (01111110). A zero is inserted
// after every five consecutive ones of payload. Frames can be aborted on
// request or because the buffer ran dry mid-frame. In both cases seven ones
// are sent.
//
// Handshake: in_valid/in_ready follow strict valid/ready rules. A byte (with
// in_last) transfers on a rising edge where in_valid && in_ready. in_ready
// depends only on registered state (buffer empty and not aborting), never on
// in_valid. A byte accepted on the same edge that the framer enters ABORT is
// dropped, because entering ABORT always clears the buffer.
module hdlc_tx_framer #(
    parameter int unsigned IDLE_ONES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       abort,
    output logic       out_bit,
    output logic       busy,
    output logic       frame_done,
    output logic       aborted,
    output logic       underrun,
    output logic [2:0] dbg_state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_OPEN  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STUFF = 3'd3;
    localparam logic [2:0] S_CLOSE = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;

    // The registered state always describes the bit on out_bit this cycle.
    logic [2:0] state_q,     state_d;
    logic [2:0] cnt_q,       cnt_d;        // bit index within flag/byte/abort run
    logic [2:0] ones_q,      ones_d;       // consecutive payload ones
    logic [7:0] sr_q,        sr_d;         // byte being serialised
    logic       last_q,      last_d;       // byte in sr_q ends the frame
    logic       end_pend_q,  end_pend_d;   // stuffed zero follows the byte's 8th bit
    logic       buf_full_q,  buf_full_d;
    logic [7:0] buf_data_q,  buf_data_d;
    logic       buf_last_q,  buf_last_d;
    logic       und_cause_q, und_cause_d;  // current abort was caused by underrun
    logic       out_bit_q,   out_bit_d;
    logic       done_q,      done_d;
    logic       aborted_q,   aborted_d;
    logic       underrun_q,  underrun_d;

    logic       accept;
    logic       cur_bit;
    logic [2:0] ones_inc;
    logic       byte_end;
    logic       load_buf;
    logic       enter_abort;
    logic       abort_cause;

    // Flag pattern 0,1,1,1,1,1,1,0 indexed by bit position.
    function automatic logic flag_bit(input logic [2:0] idx);
        return !(idx == 3'd0 || idx == 3'd7);
    endfunction

    assign in_ready    = !buf_full_q && (state_q != S_ABORT);
    assign accept      = in_valid && in_ready;
    assign cur_bit     = sr_q[cnt_q];
    assign ones_inc    = cur_bit ? 3'(ones_q + 3'd1) : 3'd0;

    assign out_bit     = out_bit_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = done_q;
    assign aborted     = aborted_q;
    assign underrun    = underrun_q;
    assign dbg_state_o = state_q;

    // Next-state, stuffing and holding-buffer control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ones_d      = ones_q;
        sr_d        = sr_q;
        last_d      = last_q;
        end_pend_d  = end_pend_q;
        buf_full_d  = buf_full_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        und_cause_d = und_cause_q;
        load_buf    = 1'b0;
        enter_abort = 1'b0;
        abort_cause = 1'b0;
        byte_end    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (IDLE_ONES != 0) begin
                    cnt_d = 3'd0;
                    if (buf_full_q) begin
                        state_d = S_OPEN;
                        ones_d  = 3'd0;
                    end
                end else if (cnt_q == 3'd7) begin
                    // A new frame may only begin at a flag boundary.
                    cnt_d = 3'd0;
                    if (buf_full_q) begin
                        state_d = S_OPEN;
                        ones_d  = 3'd0;
                    end
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            S_OPEN: begin
                ones_d = 3'd0;
                if (abort) begin
                    enter_abort = 1'b1;
                end else if (cnt_q == 3'd7) begin
                    load_buf = 1'b1;
                    state_d  = S_DATA;
                    cnt_d    = 3'd0;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            S_DATA: begin
                if (abort) begin
                    enter_abort = 1'b1;
                    abort_cause = (cnt_q == 3'd7) && (ones_inc != 3'd5) &&
                                  !last_q && !buf_full_q;
                end else if (ones_inc == 3'd5) begin
                    state_d    = S_STUFF;
                    ones_d     = 3'd0;
                    cnt_d      = 3'(cnt_q + 3'd1);
                    end_pend_d = (cnt_q == 3'd7);
                end else begin
                    ones_d = ones_inc;
                    if (cnt_q == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        cnt_d = 3'(cnt_q + 3'd1);
                    end
                end
            end
            S_STUFF: begin
                ones_d     = 3'd0;
                end_pend_d = 1'b0;
                if (abort) begin
                    enter_abort = 1'b1;
                    abort_cause = end_pend_q && !last_q && !buf_full_q;
                end else if (end_pend_q) begin
                    byte_end = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CLOSE: begin
                if (cnt_q == 3'd7) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            S_ABORT: begin
                if (cnt_q == 3'd6) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd7;
            end
        endcase

        // End of a byte: close, chain the next byte with no gap, or underrun.
        if (byte_end) begin
            cnt_d = 3'd0;
            if (last_q) begin
                state_d = S_CLOSE;
            end else if (buf_full_q) begin
                load_buf = 1'b1;
                state_d  = S_DATA;
            end else begin
                enter_abort = 1'b1;
                abort_cause = 1'b1;
            end
        end

        if (enter_abort) begin
            state_d     = S_ABORT;
            cnt_d       = 3'd0;
            ones_d      = 3'd0;
            end_pend_d  = 1'b0;
            und_cause_d = abort_cause;
        end

        if (enter_abort) begin
            buf_full_d = 1'b0;
        end else if (load_buf) begin
            sr_d       = buf_data_q;
            last_d     = buf_last_q;
            buf_full_d = 1'b0;
        end else if (accept) begin
            buf_full_d = 1'b1;
            buf_data_d = in_data;
            buf_last_d = in_last;
        end
    end

    // Decode the line bit and status pulses for the cycle being entered.
    always_comb begin
        out_bit_d = 1'b1;
        case (state_d)
            S_IDLE:  out_bit_d = (IDLE_ONES != 0) ? 1'b1 : flag_bit(cnt_d);
            S_OPEN:  out_bit_d = flag_bit(cnt_d);
            S_CLOSE: out_bit_d = flag_bit(cnt_d);
            S_DATA:  out_bit_d = sr_d[cnt_d];
            S_STUFF: out_bit_d = 1'b0;
            default: out_bit_d = 1'b1;
        endcase
        done_d     = (state_d == S_CLOSE) && (cnt_d == 3'd7);
        aborted_d  = (state_d == S_ABORT) && (cnt_d == 3'd6);
        underrun_d = aborted_d && und_cause_d;
    end

    // State registers; reset looks like the end of an idle flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd7;
            ones_q      <= 3'd0;
            sr_q        <= 8'd0;
            last_q      <= 1'b0;
            end_pend_q  <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_data_q  <= 8'd0;
            buf_last_q  <= 1'b0;
            und_cause_q <= 1'b0;
            out_bit_q   <= 1'b1;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ones_q      <= ones_d;
            sr_q        <= sr_d;
            last_q      <= last_d;
            end_pend_q  <= end_pend_d;
            buf_full_q  <= buf_full_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            und_cause_q <= und_cause_d;
            out_bit_q   <= out_bit_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench for hdlc_tx_framer: a line-level model (queue of upcoming line bits,
// refilled from flag/stuffing/abort rules) checked every cycle, plus directed
// scenarios with literal expected bit strings.
module tb_hdlc_tx_framer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       abort = 1'b0;
    logic       out_bit;
    logic       busy;
    logic       frame_done;
    logic       aborted;
    logic       underrun;
    logic [2:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    hdlc_tx_framer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .abort      (abort),
        .out_bit    (out_bit),
        .busy       (busy),
        .frame_done (frame_done),
        .aborted    (aborted),
        .underrun   (underrun),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- line model ----------------
    localparam logic [2:0] T_IDLE = 3'd0, T_OPEN = 3'd1, T_DATA = 3'd2,
                           T_CLOSE = 3'd3, T_ABORT = 3'd4;

    typedef struct packed {
        logic       b;
        logic       bsy;
        logic       done;
        logic       abt;
        logic       und;
        logic [2:0] tag;
    } ent_t;

    logic [7:0] flag_seq = 8'b01111110;
    ent_t       cur;
    ent_t       lq[$];
    logic       mvalid = 1'b0;
    logic       mbuf_full = 1'b0;
    logic [7:0] mbuf_data = 8'd0;
    logic       mbuf_last = 1'b0;
    logic       mlast = 1'b0;
    int         mones = 0;
    logic       exp_ready;

    function automatic ent_t mk(input logic b, input logic bsy, input logic done,
                                input logic abt, input logic und, input logic [2:0] tag);
        ent_t e;
        e.b = b; e.bsy = bsy; e.done = done; e.abt = abt; e.und = und; e.tag = tag;
        return e;
    endfunction

    // Line bits for one payload byte, LSB first, zero after every fifth one.
    function automatic void stuff_seq(input logic [7:0] d, input int ones_in,
                                      output logic [15:0] bits, output int n,
                                      output int ones_out);
        int o;
        o = ones_in;
        n = 0;
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            bits[n[3:0]] = d[i];
            n++;
            if (d[i]) o++; else o = 0;
            if (o == 5) begin
                bits[n[3:0]] = 1'b0;
                n++;
                o = 0;
            end
        end
        ones_out = o;
    endfunction

    task automatic push_flag(input logic [2:0] tag, input logic done_last);
        for (int i = 0; i < 8; i++)
            lq.push_back(mk(flag_seq[i], tag != T_IDLE, done_last && (i == 7), 1'b0, 1'b0, tag));
    endtask

    task automatic push_abort(input logic und);
        for (int i = 0; i < 7; i++)
            lq.push_back(mk(1'b1, 1'b1, 1'b0, i == 6, und && (i == 6), T_ABORT));
    endtask

    task automatic load_byte();
        logic [15:0] bits;
        int          n;
        int          o;
        stuff_seq(mbuf_data, mones, bits, n, o);
        mones = o;
        for (int i = 0; i < n; i++)
            lq.push_back(mk(bits[i], 1'b1, 1'b0, 1'b0, 1'b0, T_DATA));
        mlast = mbuf_last;
        mbuf_full = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs seen at it.
    task automatic model_step();
        logic acc;
        logic ent_abt;
        logic und;
        if (reset) begin
            cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, T_IDLE);
            lq.delete();
            mbuf_full = 1'b0;
            mones = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            acc = in_valid && !mbuf_full && (cur.tag != T_ABORT);
            ent_abt = 1'b0;
            if (abort && (cur.tag == T_OPEN || cur.tag == T_DATA)) begin
                und = (lq.size() == 0) && (cur.tag == T_DATA) && !mlast && !mbuf_full;
                lq.delete();
                push_abort(und);
                mbuf_full = 1'b0;
                ent_abt = 1'b1;
            end else if (lq.size() == 0) begin
                case (cur.tag)
                    T_IDLE: begin
                        if (mbuf_full) begin
                            mones = 0;
                            push_flag(T_OPEN, 1'b0);
                        end else begin
                            push_flag(T_IDLE, 1'b0);
                        end
                    end
                    T_OPEN: load_byte();
                    T_DATA: begin
                        if (mlast) push_flag(T_CLOSE, 1'b1);
                        else if (mbuf_full) load_byte();
                        else begin
                            push_abort(1'b1);
                            mbuf_full = 1'b0;
                            ent_abt = 1'b1;
                        end
                    end
                    default: push_flag(T_IDLE, 1'b0);
                endcase
            end
            cur = lq.pop_front();
            if (acc && !ent_abt) begin
                mbuf_full = 1'b1;
                mbuf_data = in_data;
                mbuf_last = in_last;
            end
        end
        exp_ready = !mbuf_full && (cur.tag != T_ABORT);
    endtask

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b exp=%b dbg_state=%0d", name, $time, got, exp, dbg_state);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #2;
            if (mvalid) begin
                cmp("out_bit",    out_bit,    cur.b);
                cmp("busy",       busy,       cur.bsy);
                cmp("frame_done", frame_done, cur.done);
                cmp("aborted",    aborted,    cur.abt);
                cmp("underrun",   underrun,   cur.und);
                cmp("in_ready",   in_ready,   exp_ready);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [0:63] cap_bit, cap_done, cap_abt, cap_und, cap_busy, cap_rdy;
    logic        rnd_done = 1'b0;

    // Called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int k = 0; k < 300 && !ok; k++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("send_handshake", 64'(ok), 64'(1'b1));
    endtask

    // Wait for busy, then record n cycles; pulse abort during cycle abort_at.
    task automatic capture(input int n, input int abort_at);
        int k;
        k = 0;
        while (!busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("busy_start", 64'(busy), 64'(1'b1));
        cap_bit = '0; cap_done = '0; cap_abt = '0; cap_und = '0; cap_busy = '0; cap_rdy = '0;
        for (int i = 0; i < n; i++) begin
            cap_bit[i]  = out_bit;
            cap_done[i] = frame_done;
            cap_abt[i]  = aborted;
            cap_und[i]  = underrun;
            cap_busy[i] = busy;
            cap_rdy[i]  = in_ready;
            abort = (i == abort_at);
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] sb;
        int          sn;
        int          so;
        logic [7:0]  d;
        int          nb;
        int          gap;

        // Model pins: stuffing rule against hand-derived strings.
        stuff_seq(8'h7E, 0, sb, sn, so);
        chk("pin_7e_len", 64'(sn), 64'd9);
        chk("pin_7e_bits", 64'(sb[8:0]), 64'(9'b010111110));
        stuff_seq(8'hFF, 0, sb, sn, so);
        chk("pin_ff0_bits", 64'(sb[8:0]), 64'(9'b111011111));
        chk("pin_ff0_ones", 64'(so), 64'd3);
        stuff_seq(8'hFF, 3, sb, sn, so);
        chk("pin_ff3_len", 64'(sn), 64'd10);
        chk("pin_ff3_bits", 64'(sb[9:0]), 64'(10'b1011111011));

        // Reset state and idle flags.
        repeat (3) @(negedge clk);
        chk("rst_out_bit", 64'(out_bit), 64'(1'b1));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_pulses", 64'({frame_done, aborted, underrun}), 64'(3'b000));
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("idle_flag", 64'(out_bit), 64'(flag_seq[i % 8]));
        end
        chk("idle_busy", 64'(busy), 64'(1'b0));
        chk("idle_ready", 64'(in_ready), 64'(1'b1));

        // Single 0x7E with stuffing, then closing flag.
        fork
            send_byte(8'h7E, 1'b1);
            capture(25, -1);
        join
        chk("s7e_bits", 64'(cap_bit[0:24]), 64'({8'b01111110, 9'b011111010, 8'b01111110}));
        chk("s7e_done", 64'(cap_done[0:24]), 64'(25'd1));
        idle_cycles(20);

        // 0xFF, 0xFF(last): stuffing across the byte boundary.
        fork
            begin
                send_byte(8'hFF, 1'b0);
                send_byte(8'hFF, 1'b1);
            end
            capture(35, -1);
        join
        chk("sff_bits", 64'(cap_bit[0:34]),
            64'({8'b01111110, 19'b1111101111101111101, 8'b01111110}));
        chk("sff_done", 64'(cap_done[0:34]), 64'(35'd1));
        idle_cycles(20);

        // 0x00 not last, nothing follows: underrun abort.
        fork
            send_byte(8'h00, 1'b0);
            capture(24, -1);
        join
        chk("und_bits", 64'(cap_bit[0:22]), 64'({8'b01111110, 8'b00000000, 7'b1111111}));
        chk("und_aborted", 64'(cap_abt[0:22]), 64'(23'd1));
        chk("und_underrun", 64'(cap_und[0:22]), 64'(23'd1));
        chk("und_busy_after", 64'(cap_busy[23]), 64'(1'b0));
        idle_cycles(20);

        // Requested abort during the 3rd data bit of 0x55 with buffer full.
        fork
            begin
                send_byte(8'h55, 1'b0);
                send_byte(8'h12, 1'b1);
            end
            capture(19, 10);
        join
        chk("abt_bits", 64'(cap_bit[0:17]), 64'({8'b01111110, 3'b101, 7'b1111111}));
        chk("abt_aborted", 64'(cap_abt[0:17]), 64'(18'd1));
        chk("abt_underrun", 64'(cap_und[0:17]), 64'(18'd0));
        chk("abt_ready_low", 64'(cap_rdy[11:17]), 64'(7'd0));
        chk("abt_ready_after", 64'(cap_rdy[18]), 64'(1'b1));
        chk("abt_busy_after", 64'(cap_busy[18]), 64'(1'b0));
        idle_cycles(20);

        // Reset in the middle of a data byte.
        send_byte(8'hA5, 1'b1);
        capture(12, -1);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_out_bit", 64'(out_bit), 64'(1'b1));
        chk("mrst_busy", 64'(busy), 64'(1'b0));
        chk("mrst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("mrst_pulses", 64'({frame_done, aborted, underrun}), 64'(3'b000));
        reset = 1'b0;
        idle_cycles(30);

        // Random frames, gaps and aborts against the line model.
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    nb = $urandom_range(1, 4);
                    for (int b = 0; b < nb; b++) begin
                        gap = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 20);
                        repeat (gap) @(negedge clk);
                        d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                        send_byte(d, b == nb - 1);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    abort = ($urandom_range(0, 99) < 2);
                end
                abort = 1'b0;
            end
        join
        idle_cycles(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
